// File: rtl/des_pkg.sv
// Shared types and constants for the DES round sequencer.
package des_pkg;
    localparam int DES_ROUNDS = 16;
    localparam int DES_HALF_W = 32;
    localparam int DES_BLK_W  = 64;
    localparam int DES_KIDX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FREQ,
        ST_XOR,
        ST_XWAIT,
        ST_DONE
    } des_rc_state_t;
endpackage

// File: rtl/des_key_idx_gen.sv
// Round counter plus encrypt/decrypt subkey index mapping.
module des_key_idx_gen
    import des_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  dec_in,
    input  logic                  inc,
    output logic [DES_KIDX_W:1]   key_idx,
    output logic                  last
);
    localparam logic [DES_KIDX_W-1:0] RND_LAST = DES_KIDX_W'(DES_ROUNDS - 1);

    logic [DES_KIDX_W-1:0] round;
    logic                  dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            round <= '0;
            dec   <= 1'b0;
        end else if (clr) begin
            round <= '0;
            dec   <= dec_in;
        end else if (inc && !last) begin
            // saturates at the last round so the count never wraps mid-block
            round <= round + 1'b1;
        end
    end

    assign last    = (round == RND_LAST);
    assign key_idx = dec ? (RND_LAST - round) : round;
endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for the 16 DES Feistel rounds over an external f-unit and XOR32 unit.
// Optional f_ack watchdog and err output: define DES_ROUND_CTRL_WATCHDOG_EN.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [DES_BLK_W:1]    blk_in,
    output logic                  busy,
    output logic                  done,
    output logic [DES_BLK_W:1]    blk_out,
    output logic [DES_KIDX_W:1]   key_idx,
    output logic                  f_req,
    output logic [DES_HALF_W:1]   f_r,
    input  logic                  f_ack,
    input  logic [DES_HALF_W:1]   f_data,
    output logic                  xor_sel,
    output logic [DES_HALF_W:1]   xor_a,
    output logic [DES_HALF_W:1]   xor_b,
    input  logic [DES_HALF_W:1]   xor_out,
    input  logic                  xor_finish
`ifdef DES_ROUND_CTRL_WATCHDOG_EN
    ,
    output logic                  err
`endif
);
    des_rc_state_t         state, state_nxt;
    logic [DES_HALF_W:1]   l_q, r_q, f_q;
    logic                  last, rnd_clr, rnd_inc;

    des_key_idx_gen u_kidx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rnd_clr),
        .dec_in  (decrypt),
        .inc     (rnd_inc),
        .key_idx (key_idx),
        .last    (last)
    );

`ifdef DES_ROUND_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    assign wd_expire = (state == ST_FREQ) && !f_ack && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            err    <= wd_expire;
            wd_cnt <= (state == ST_FREQ && !f_ack && !wd_expire) ? wd_cnt + 1'b1 : '0;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        rnd_clr   = 1'b0;
        rnd_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FREQ;
                    rnd_clr   = 1'b1;
                end
            end
            ST_FREQ: begin
                if (f_ack) begin
                    state_nxt = ST_XOR;
                end
`ifdef DES_ROUND_CTRL_WATCHDOG_EN
                else if (wd_expire) begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            ST_XOR:   state_nxt = ST_XWAIT;
            ST_XWAIT: begin
                if (xor_finish) begin
                    if (last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        rnd_inc   = 1'b1;
                        state_nxt = ST_FREQ;
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            f_q     <= '0;
            blk_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                l_q <= blk_in[64:33];
                r_q <= blk_in[32:1];
            end
            if (state == ST_FREQ && f_ack) begin
                f_q <= f_data;
            end
            if (state == ST_XWAIT && xor_finish) begin
                l_q <= r_q;
                r_q <= xor_out;
                // capture {R16, L16} on the way into DONE so it is valid alongside done
                if (last) begin
                    blk_out <= {xor_out, r_q};
                end
            end
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign f_req   = (state == ST_FREQ);
    assign xor_sel = (state == ST_XOR);
    assign f_r     = r_q;
    assign xor_a   = l_q;
    assign xor_b   = f_q;
endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl with behavioural f-unit and XOR32 models.
module tb_des_round_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, decrypt = 1'b0;
    logic [63:0] blk_in = '0;
    logic        busy, done, f_req, f_ack, xor_sel;
    logic [63:0] blk_out;
    logic [3:0]  key_idx;
    logic [31:0] f_r, f_data, xor_a, xor_b;
    logic [31:0] xor_out = '0;
    logic        xor_finish = 1'b0;
`ifdef DES_ROUND_CTRL_WATCHDOG_EN
    logic        err;
`endif

    des_round_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .blk_in(blk_in),
        .busy(busy), .done(done), .blk_out(blk_out), .key_idx(key_idx),
        .f_req(f_req), .f_r(f_r), .f_ack(f_ack), .f_data(f_data),
        .xor_sel(xor_sel), .xor_a(xor_a), .xor_b(xor_b),
        .xor_out(xor_out), .xor_finish(xor_finish)
`ifdef DES_ROUND_CTRL_WATCHDOG_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    logic        fmode = 1'b0, ack_en = 1'b1;
    int          ack_dly = 0, wcnt = 0, cyc = 0;
    int          n_xsel = 0, n_ack = 0, fr_bad = 0;
    logic [63:0] kseq = '0;
    logic        prev_freq = 1'b0;
    logic [31:0] prev_fr = '0;
    logic [3:0]  prev_kidx = '0;

    assign f_ack  = ack_en && f_req && (wcnt >= ack_dly);
    assign f_data = fmode ? {28'h0, key_idx} : 32'h0;

    // f-unit wait counter, XOR unit (garbage unless finishing), and monitors
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        wcnt       <= (f_req && !f_ack) ? wcnt + 1 : 0;
        xor_finish <= xor_sel;
        xor_out    <= xor_sel ? (xor_a ^ xor_b) : 32'hDEAD_BEEF;
        if (xor_sel) n_xsel <= n_xsel + 1;
        if (f_req && f_ack) begin
            n_ack <= n_ack + 1;
            kseq  <= {key_idx, kseq[63:4]};
        end
        if (f_req && prev_freq && (f_r != prev_fr || key_idx != prev_kidx)) fr_bad <= fr_bad + 1;
        prev_freq <= f_req;
        prev_fr   <= f_r;
        prev_kidx <= key_idx;
    end

    int n_cmp = 0, n_bad = 0;
    int t_start = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] feistel(input logic [63:0] b, input logic dec, input logic fm);
        logic [31:0] l, r, t;
        l = b[63:32];
        r = b[31:0];
        for (int i = 0; i < 16; i++) begin
            t = l ^ (fm ? {28'h0, 4'(dec ? 15 - i : i)} : 32'h0);
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    task automatic pulse_start(input logic [63:0] b, input logic dec);
        start   = 1'b1;
        blk_in  = b;
        decrypt = dec;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clk);
        end
        lat = cyc - t_start;
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_busy"},    64'(busy),    64'd0);
        chk({tag, "_done"},    64'(done),    64'd0);
        chk({tag, "_blk_out"}, blk_out,      64'd0);
        chk({tag, "_key_idx"}, 64'(key_idx), 64'd0);
        chk({tag, "_f_req"},   64'(f_req),   64'd0);
        chk({tag, "_xor_sel"}, 64'(xor_sel), 64'd0);
        chk({tag, "_f_r"},     64'(f_r),     64'd0);
        chk({tag, "_xor_ab"},  {xor_a, xor_b}, 64'd0);
    endtask

    localparam logic [63:0] B1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] B2 = 64'hF0E1D2C3B4A59687;
    localparam logic [63:0] B3 = 64'h1122334455667788;

    initial begin
        int lat, b0, bf, seen;
        logic [63:0] prev_blk;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_rst("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // zero f-function: 16 rounds leave halves in place, preoutput swaps them
        fmode = 1'b0;
        b0 = n_xsel;
        pulse_start(B1, 1'b0);
        wait_done("t1", lat);
        chk("t1_blk_out", blk_out, 64'h89ABCDEF01234567);
        chk("t1_latency", 64'(lat), 64'd49);
        chk("t1_xor_sel_cnt", 64'(n_xsel - b0), 64'd16);
        @(negedge clk);
        chk("t1_busy_drop", 64'(busy), 64'd0);
        chk("t1_done_1cyc", 64'(done), 64'd0);

        // key-dependent f: encrypt then decrypt, each started in the IDLE cycle after done
        fmode = 1'b1;
        b0 = n_ack;
        pulse_start(B1, 1'b0);
        wait_done("t2", lat);
        chk("t2_blk_out", blk_out, feistel(B1, 1'b0, 1'b1));
        chk("t2_kseq", kseq, 64'hFEDCBA9876543210);
        chk("t2_ack_cnt", 64'(n_ack - b0), 64'd16);
        @(negedge clk);
        b0 = n_ack;
        pulse_start(B1, 1'b1);
        wait_done("t3", lat);
        chk("t3_blk_out", blk_out, feistel(B1, 1'b1, 1'b1));
        chk("t3_kseq", kseq, 64'h0123456789ABCDEF);
        chk("t3_latency", 64'(lat), 64'd49);
        @(negedge clk);

        // 3-cycle ack delay every round
        ack_dly = 3;
        bf = fr_bad;
        pulse_start(B2, 1'b0);
        wait_done("t4", lat);
        chk("t4_latency", 64'(lat), 64'd97);
        chk("t4_blk_out", blk_out, feistel(B2, 1'b0, 1'b1));
        chk("t4_freq_stable", 64'(fr_bad - bf), 64'd0);
        ack_dly = 0;
        @(negedge clk);

        // start while busy and during DONE is ignored
        fmode = 1'b0;
        pulse_start(B2, 1'b0);
        repeat (10) @(negedge clk);
        start  = 1'b1;
        blk_in = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", lat);
        chk("t5_latency", 64'(lat), 64'd49);
        chk("t5_blk_out", blk_out, {B2[31:0], B2[63:32]});
        start  = 1'b1;
        blk_in = B1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_done_start_ign", 64'(busy), 64'd0);
        pulse_start(B3, 1'b0);
        chk("t5_idle_start_busy", 64'(busy), 64'd1);
        wait_done("t5b", lat);
        chk("t5b_latency", 64'(lat), 64'd49);
        chk("t5b_blk_out", blk_out, {B3[31:0], B3[63:32]});
        @(negedge clk);

        // reset in round 7 aborts the block
        fmode = 1'b1;
        pulse_start(B1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (f_req && key_idx == 4'd7) break;
            @(negedge clk);
        end
        chk("t6_reach_r7", 64'(key_idx), 64'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check_rst("t6_rst");
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("t6_no_done", 64'(seen), 64'd0);
        pulse_start(B2, 1'b1);
        wait_done("t6b", lat);
        chk("t6b_latency", 64'(lat), 64'd49);
        chk("t6b_blk_out", blk_out, feistel(B2, 1'b1, 1'b1));
        @(negedge clk);

`ifdef DES_ROUND_CTRL_WATCHDOG_EN
        // f_ack never arrives: timeout after 8 FREQ cycles
        prev_blk = blk_out;
        ack_en   = 1'b0;
        chk("t7_err_idle", 64'(err), 64'd0);
        pulse_start(B3, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if (err) break;
            @(negedge clk);
        end
        lat = cyc - t_start;
        chk("t7_err_seen", 64'(err), 64'd1);
        chk("t7_err_cycle", 64'(lat), 64'd9);
        chk("t7_freq_drop", 64'(f_req), 64'd0);
        chk("t7_idle", 64'(busy), 64'd0);
        chk("t7_blk_hold", blk_out, prev_blk);
        chk("t7_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("t7_err_1cyc", 64'(err), 64'd0);
        ack_en = 1'b1;
`else
        prev_blk = blk_out;
        chk("t7_blk_hold", blk_out, prev_blk ^ 64'(busy));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Sequencer for the 16 DES Feistel rounds. It holds the L/R half-block registers and requests the round function from an external f-unit using a req/ack handshake. It drives the shared 32-bit XOR unit (select/finish protocol) to form R' = L ^ f(R,K), and steps the subkey index forward for encryption or backward for decryption. It sits between the initial/final permutation stages and the f-unit/XOR32 datapath.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles to wait for f_ack. Used only when the watchdog is compiled in.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse that starts a block; sampled only in IDLE.
- decrypt  in  1  sampled with start; 1 selects reverse key order.
- blk_in  in  [64:1]  post-IP block; L0 = [64:33], R0 = [32:1].
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when blk_out is valid.
- blk_out  out  [64:1]  preoutput {R16, L16}; holds until the next done.
- key_idx  out  [4:1]  subkey index 0..15 for the current round.
- f_req  out  1  request to the f-unit; held until f_ack.
- f_r  out  [32:1]  current R, stable while f_req is high.
- f_ack  in  1  f-unit response valid.
- f_data  in  [32:1]  f(R,K), captured when f_ack is high.
- xor_sel  out  1  XOR unit select, asserted for exactly one cycle per round.
- xor_a  out  [32:1]  current L.
- xor_b  out  [32:1]  captured f result.
- xor_out  in  [32:1]  XOR unit result.
- xor_finish  in  1  XOR unit finish flag; high the cycle after xor_sel.

## Operation
- The state machine has five states: IDLE, FREQ, XOR, XWAIT, DONE.
- IDLE:
  - On start, load L <= blk_in[64:33] and R <= blk_in[32:1].
  - Latch decrypt, clear round <= 0, then go to FREQ.
  - start outside IDLE is ignored.
- FREQ: f_req = 1. When f_ack is high (same-cycle ack allowed), capture f_data into F and go to XOR.
- XOR: xor_sel = 1 for one cycle, with xor_a = L and xor_b = F. Go to XWAIT.
- XWAIT: wait for xor_finish = 1. Then:
  - L <= R and R <= xor_out.
  - If round == 15, go to DONE; otherwise round <= round+1 and go to FREQ.
- DONE: blk_out <= {R, L} (the final swap is undone), done = 1 for one cycle, then go to IDLE.
- key_idx = round when encrypting and 15 - round when decrypting. It is valid whenever f_req is high.
- round is a 4-bit counter and never wraps mid-block. Exactly 16 XOR operations are issued per block.
- xor_out is ignored unless xor_finish is high. A finish seen outside XWAIT is ignored.
- Reset mid-operation returns to IDLE, aborting the block; no done is produced.

## Timing
- Reset values: busy = 0, done = 0, blk_out = 0, key_idx = 0, f_req = 0, xor_sel = 0, f_r = 0, xor_a = 0, xor_b = 0, err = 0 (when present).
- Per round: FREQ for 1 + (f_ack wait) cycles, then XOR for 1 cycle, then XWAIT for 1 cycle, assuming the XOR unit returns finish one cycle after select.
- Minimum latency is 48 round cycles plus 1 DONE cycle. done asserts 49 cycles after the start cycle when f_ack is tied high.
- busy drops in the cycle after done. A new start is accepted from that IDLE cycle onward.

## Configuration
- DES_ROUND_CTRL_WATCHDOG_EN defined:
  - A counter runs in FREQ. If f_ack has not arrived after TIMEOUT_CYCLES cycles, the block drops f_req, pulses the output err for one cycle and returns to IDLE.
  - No done is produced and blk_out is unchanged.
- DES_ROUND_CTRL_WATCHDOG_EN undefined: FREQ waits indefinitely, and the err port and counter do not exist.

## Structure
- Shared package des_pkg contains:
  - the state enum des_rc_state_t;
  - the constants DES_ROUNDS = 16, DES_HALF_W = 32 and DES_BLK_W = 64.
- One natural sub-module, des_key_idx_gen: the round counter plus the encrypt/decrypt index mapping.

## Test plan
- f-model returns 0 with immediate ack, encrypt, blk_in = 0x0123456789ABCDEF -> blk_out = 0x89ABCDEF01234567; done 49 cycles after start; exactly 16 xor_sel pulses.
- f-model returns {28'h0, key_idx}, encrypt vs decrypt on the same blk_in -> key_idx sequence 0..15 vs 15..0, checked against a bench Feistel model.
- f_ack delayed by 3 cycles every round -> f_req and f_r stay stable while waiting; done at cycle 97; correct blk_out.
- start pulsed while busy and again during DONE -> both ignored; a start in the IDLE cycle after done starts a new block.
- rst_n low in round 7 -> all outputs return to reset values on the next edge; no done; the next block completes normally.
- Watchdog build with TIMEOUT_CYCLES = 8 and f_ack never asserted -> err pulses 8 cycles into FREQ; the block returns to IDLE; blk_out is unchanged.
